// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronizes and filters the raw PS/2 pins, assembles
// 11-bit frames and folds E0/F0 prefixes into single-cycle key events.
module ps2_kbd_rx #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       key_valid,
   output logic [7:0] key_code,
   output logic       key_ext,
   output logic       key_release,
   output logic       frame_err
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DATA   = 2'd1,
      S_PARITY = 2'd2,
      S_STOP   = 2'd3
   } state_t;

   // Odd parity over the eight data bits plus the parity bit.
   function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
      return ^{d, p};
   endfunction

   logic          clk_meta_r, clk_sync_r, data_meta_r, data_sync_r;
   logic          fclk_r, fclk_d_r;
   logic [FW-1:0] filt_cnt_r;
   logic          fall_s;

   state_t        state_r, state_nxt_s;
   logic [2:0]    bit_cnt_r;
   logic [7:0]    shift_r;
   logic          parity_r;
   logic [TW-1:0] to_cnt_r;
   logic          ext_pend_r, brk_pend_r;

   logic          timeout_s, start_s, shift_en_s, par_en_s;
   logic          frame_good_s, frame_bad_s, is_e0_s, is_f0_s, emit_s;

   // Two-flop synchronizers for both PS/2 pins.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clk_meta_r  <= 1'b1;
         clk_sync_r  <= 1'b1;
         data_meta_r <= 1'b1;
         data_sync_r <= 1'b1;
      end else begin
         clk_meta_r  <= ps2_clk;
         clk_sync_r  <= clk_meta_r;
         data_meta_r <= ps2_data;
         data_sync_r <= data_meta_r;
      end
   end

   // Glitch filter: fclk follows the synced clock only after FILTER_LEN differing samples.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fclk_r     <= 1'b1;
         fclk_d_r   <= 1'b1;
         filt_cnt_r <= '0;
      end else begin
         fclk_d_r <= fclk_r;
         if (clk_sync_r == fclk_r) begin
            filt_cnt_r <= '0;
         end else if (filt_cnt_r == FW'(FILTER_LEN - 1)) begin
            fclk_r     <= clk_sync_r;
            filt_cnt_r <= '0;
         end else begin
            filt_cnt_r <= filt_cnt_r + FW'(1);
         end
      end
   end

   assign fall_s = fclk_d_r & ~fclk_r;
   // A fall in the same cycle as the limit wins, so timeout excludes it.
   assign timeout_s = (state_r != S_IDLE) && !fall_s && (to_cnt_r == TW'(TIMEOUT_CYCLES - 1));

   // Frame FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Frame FSM next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (fall_s && !data_sync_r) state_nxt_s = S_DATA;
            else                        state_nxt_s = S_IDLE;
         end
         S_DATA: begin
            if (timeout_s)                           state_nxt_s = S_IDLE;
            else if (fall_s && bit_cnt_r == 3'd7)    state_nxt_s = S_PARITY;
            else                                     state_nxt_s = S_DATA;
         end
         S_PARITY: begin
            if (timeout_s)   state_nxt_s = S_IDLE;
            else if (fall_s) state_nxt_s = S_STOP;
            else             state_nxt_s = S_PARITY;
         end
         S_STOP: begin
            if (timeout_s || fall_s) state_nxt_s = S_IDLE;
            else                     state_nxt_s = S_STOP;
         end
         default: state_nxt_s = S_IDLE;
      endcase
   end

   // Frame FSM control decode.
   always_comb begin
      start_s      = 1'b0;
      shift_en_s   = 1'b0;
      par_en_s     = 1'b0;
      frame_good_s = 1'b0;
      frame_bad_s  = timeout_s;
      case (state_r)
         S_IDLE:   start_s    = fall_s & ~data_sync_r;
         S_DATA:   shift_en_s = fall_s;
         S_PARITY: par_en_s   = fall_s;
         S_STOP: begin
            if (fall_s) begin
               frame_good_s = data_sync_r & odd_parity_ok(shift_r, parity_r);
               frame_bad_s  = ~(data_sync_r & odd_parity_ok(shift_r, parity_r));
            end else begin
               frame_good_s = 1'b0;
               frame_bad_s  = timeout_s;
            end
         end
         default: begin
            start_s      = 1'b0;
            frame_good_s = 1'b0;
         end
      endcase
   end

   assign is_e0_s = (shift_r == 8'hE0);
   assign is_f0_s = (shift_r == 8'hF0);
   assign emit_s  = frame_good_s & ~is_e0_s & ~is_f0_s;

   // Shift register, bit counter and inter-fall timeout counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bit_cnt_r <= 3'd0;
         shift_r   <= 8'h00;
         parity_r  <= 1'b0;
         to_cnt_r  <= '0;
      end else begin
         if (start_s)         bit_cnt_r <= 3'd0;
         else if (shift_en_s) bit_cnt_r <= bit_cnt_r + 3'd1;
         if (shift_en_s) shift_r  <= {data_sync_r, shift_r[7:1]};
         if (par_en_s)   parity_r <= data_sync_r;
         if (state_r == S_IDLE || fall_s) to_cnt_r <= '0;
         else                             to_cnt_r <= to_cnt_r + TW'(1);
      end
   end

   // Prefix tracking and registered key event outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ext_pend_r  <= 1'b0;
         brk_pend_r  <= 1'b0;
         key_valid   <= 1'b0;
         frame_err   <= 1'b0;
         key_code    <= 8'h00;
         key_ext     <= 1'b0;
         key_release <= 1'b0;
      end else begin
         key_valid <= emit_s;
         frame_err <= frame_bad_s;
         if (frame_bad_s || emit_s) begin
            ext_pend_r <= 1'b0;
            brk_pend_r <= 1'b0;
         end else if (frame_good_s && is_e0_s) begin
            ext_pend_r <= 1'b1;
         end else if (frame_good_s && is_f0_s) begin
            brk_pend_r <= 1'b1;
         end
         if (emit_s) begin
            key_code    <= shift_r;
            key_ext     <= ext_pend_r;
            key_release <= brk_pend_r;
         end
      end
   end

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed bench for ps2_kbd_rx: a table of frames with expected events plus
// hand-written timeout, glitch and mid-frame reset sequences.
`timescale 1ns/1ps
module tb_ps2_kbd_rx;

   localparam int TO = 200;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic       key_valid, key_ext, key_release, frame_err;
   logic [7:0] key_code;

   ps2_kbd_rx #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .key_valid(key_valid), .key_code(key_code), .key_ext(key_ext),
      .key_release(key_release), .frame_err(frame_err)
   );

   // 1 MHz system clock: a 40-cycle PS/2 period stands for 40 us.
   always #500 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int         kv_cnt = 0, err_cnt = 0, hold_viol = 0;
   int         last_kv_cyc = 0, last_err_cyc = 0;
   logic [7:0] ev_code = 8'h00, prev_code = 8'h00;
   logic       ev_ext = 1'b0, ev_rel = 1'b0;

   // Event monitor: counts high cycles of each pulse and records the last event.
   always @(negedge clk) begin
      if (key_valid) begin
         kv_cnt      <= kv_cnt + 1;
         last_kv_cyc <= cyc;
         ev_code     <= key_code;
         ev_ext      <= key_ext;
         ev_rel      <= key_release;
      end
      if (frame_err) begin
         err_cnt      <= err_cnt + 1;
         last_err_cyc <= cyc;
      end
      if (!reset && !key_valid && key_code != prev_code) hold_viol <= hold_viol + 1;
      prev_code <= key_code;
   end

   int total = 0, passed = 0;
   int last_fall_cyc = 0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drives the first nbits of an 11-bit frame (index 0 = start bit).
   task automatic send_bits(input logic [10:0] fr, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         ps2_data = fr[i];
         wait_cyc(10);
         ps2_clk = 1'b0;
         last_fall_cyc = cyc;
         wait_cyc(20);
         ps2_clk = 1'b1;
         wait_cyc(10);
      end
      ps2_data = 1'b1;
   endtask

   function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic bad_par, input logic bad_stop);
      return {~bad_stop, (~^d) ^ bad_par, d, 1'b0};
   endfunction

   typedef struct {
      logic [7:0] data;
      logic       bad_par;
      logic       bad_stop;
      int         exp_kv;
      logic [7:0] exp_code;
      logic       exp_ext;
      logic       exp_rel;
      int         exp_err;
   } vec_t;

   vec_t vecs[14];
   int   kv0, err0;

   initial begin
      vecs[0]  = '{8'h1C, 1'b0, 1'b0, 1, 8'h1C, 1'b0, 1'b0, 0};
      vecs[1]  = '{8'hE0, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0, 0};
      vecs[2]  = '{8'hF0, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0, 0};
      vecs[3]  = '{8'h75, 1'b0, 1'b0, 1, 8'h75, 1'b1, 1'b1, 0};
      vecs[4]  = '{8'h1C, 1'b0, 1'b0, 1, 8'h1C, 1'b0, 1'b0, 0};
      vecs[5]  = '{8'hF0, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0, 0};
      vecs[6]  = '{8'h1C, 1'b1, 1'b0, 0, 8'h00, 1'b0, 1'b0, 1};
      vecs[7]  = '{8'h1C, 1'b0, 1'b0, 1, 8'h1C, 1'b0, 1'b0, 0};
      vecs[8]  = '{8'hE0, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0, 0};
      vecs[9]  = '{8'h1C, 1'b0, 1'b1, 0, 8'h00, 1'b0, 1'b0, 1};
      vecs[10] = '{8'h6B, 1'b0, 1'b0, 1, 8'h6B, 1'b0, 1'b0, 0};
      vecs[11] = '{8'hE1, 1'b0, 1'b0, 1, 8'hE1, 1'b0, 1'b0, 0};
      vecs[12] = '{8'hF0, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0, 0};
      vecs[13] = '{8'hAA, 1'b0, 1'b0, 1, 8'hAA, 1'b0, 1'b1, 0};

      // Reset state
      wait_cyc(3);
      chk("rst_key_valid", key_valid, 0);
      chk("rst_frame_err", frame_err, 0);
      chk("rst_key_code", key_code, 8'h00);
      chk("rst_key_ext", key_ext, 0);
      chk("rst_key_release", key_release, 0);
      reset = 1'b0;
      wait_cyc(20);

      for (int v = 0; v < 14; v++) begin
         kv0 = kv_cnt; err0 = err_cnt;
         send_bits(mk_frame(vecs[v].data, vecs[v].bad_par, vecs[v].bad_stop), 11);
         wait_cyc(10);
         chk($sformatf("v%0d_kv_count", v), kv_cnt - kv0, vecs[v].exp_kv);
         chk($sformatf("v%0d_err_count", v), err_cnt - err0, vecs[v].exp_err);
         if (vecs[v].exp_kv == 1) begin
            chk($sformatf("v%0d_code", v), ev_code, vecs[v].exp_code);
            chk($sformatf("v%0d_ext", v), ev_ext, vecs[v].exp_ext);
            chk($sformatf("v%0d_rel", v), ev_rel, vecs[v].exp_rel);
         end
         if (v == 0) chk("kv_latency", last_kv_cyc - last_fall_cyc, 11);
      end

      // Timeout: start + 4 data bits, then lines idle high
      kv0 = kv_cnt; err0 = err_cnt;
      send_bits(mk_frame(8'h29, 1'b0, 1'b0), 5);
      wait_cyc(250);
      chk("to_err_count", err_cnt - err0, 1);
      chk("to_kv_count", kv_cnt - kv0, 0);
      chk("to_latency", last_err_cyc - last_fall_cyc, 10 + TO + 1);
      kv0 = kv_cnt;
      send_bits(mk_frame(8'h29, 1'b0, 1'b0), 11);
      wait_cyc(10);
      chk("after_to_kv", kv_cnt - kv0, 1);
      chk("after_to_code", ev_code, 8'h29);

      // Glitch rejection: 3-cycle low pulse while idle
      kv0 = kv_cnt; err0 = err_cnt;
      ps2_clk = 1'b0;
      wait_cyc(3);
      ps2_clk = 1'b1;
      wait_cyc(40);
      chk("glitch_kv", kv_cnt - kv0, 0);
      chk("glitch_err", err_cnt - err0, 0);
      send_bits(mk_frame(8'h5A, 1'b0, 1'b0), 11);
      wait_cyc(10);
      chk("glitch_frame_kv", kv_cnt - kv0, 1);
      chk("glitch_frame_code", ev_code, 8'h5A);

      // Reset after the 5th data bit
      kv0 = kv_cnt; err0 = err_cnt;
      send_bits(mk_frame(8'h33, 1'b0, 1'b0), 6);
      reset = 1'b1;
      wait_cyc(2);
      chk("midrst_key_valid", key_valid, 0);
      chk("midrst_frame_err", frame_err, 0);
      chk("midrst_key_code", key_code, 8'h00);
      chk("midrst_key_ext", key_ext, 0);
      chk("midrst_key_release", key_release, 0);
      wait_cyc(3);
      reset = 1'b0;
      wait_cyc(300);
      chk("midrst_no_kv", kv_cnt - kv0, 0);
      chk("midrst_no_err", err_cnt - err0, 0);
      send_bits(mk_frame(8'h16, 1'b0, 1'b0), 11);
      wait_cyc(10);
      chk("midrst_frame_kv", kv_cnt - kv0, 1);
      chk("midrst_frame_code", ev_code, 8'h16);
      chk("midrst_frame_rel", ev_rel, 0);

      chk("code_hold", hold_viol, 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/ps2_kbd_rx.md
# ps2_kbd_rx

PS/2 keyboard receiver and scan-code pre-decoder for the PET keyboard path. It samples the raw PS2KeyboardClk/PS2KeyboardData pins, assembles 11-bit device-to-host frames, and strips the E0/F0 prefixes. Each key action is delivered as a single-cycle event: an 8-bit code plus extended and release flags. The downstream keyboard-matrix emulator consumes these events. The block is receive-only and never drives the PS/2 lines.

## Interface

Parameters:
- FILTER_LEN, 8: number of consecutive identical synchronized samples needed before the filtered PS/2 clock changes state.
- TIMEOUT_CYCLES, 100000: maximum number of clk cycles allowed between falling edges inside a frame.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- ps2_clk  input  1  raw PS/2 clock pin, asynchronous to clk.
- ps2_data  input  1  raw PS/2 data pin, asynchronous to clk.
- key_valid  output  1  one-cycle pulse; a key event is present on key_code/key_ext/key_release.
- key_code  output  8  scan code (set 2) of the event; held until the next event.
- key_ext  output  1  event was preceded by E0; held with key_code.
- key_release  output  1  event was preceded by F0 (break); held with key_code.
- frame_err  output  1  one-cycle pulse on a parity, stop-bit or timeout error.

## Operation

- Input conditioning:
  - ps2_clk and ps2_data each pass through a 2-FF synchronizer.
  - Filtered clock fclk resets to 1. It takes the synchronized ps2_clk value only after FILTER_LEN consecutive equal samples.
  - A fall event is the cycle in which fclk goes from 1 to 0. The synchronized data is sampled in that cycle.
- Frame FSM:
  - IDLE: a fall with data=0 (start bit) goes to DATA and clears the bit count. A fall with data=1 is ignored and the FSM stays in IDLE.
  - DATA: 8 falls shift data in LSB first. After the 8th fall, go to PARITY.
  - PARITY: the sampled bit is stored and the FSM goes to STOP.
  - STOP: on the fall, the frame is good if data=1 and the 9 bits (data plus parity) have odd parity. Either way, return to IDLE.
- Timeout:
  - A counter clears on every fall and whenever the FSM is in IDLE.
  - When the counter reaches TIMEOUT_CYCLES outside IDLE, the FSM returns to IDLE and pulses frame_err.
- Byte handling on a good frame:
  - 0xE0 sets ext_pend. Nothing is emitted.
  - 0xF0 sets brk_pend. Nothing is emitted.
  - Any other byte loads key_code=byte, key_ext=ext_pend and key_release=brk_pend. It pulses key_valid and clears both pend flags.
  - 0xE1 and 0xAA have no special handling and are emitted as ordinary codes.
- Bad frame (parity or stop error) or timeout:
  - frame_err pulses and no key_valid is issued.
  - ext_pend and brk_pend are both cleared.
- Reset values:
  - key_valid=0, frame_err=0, key_code=0x00, key_ext=0, key_release=0.
  - fclk=1, FSM in IDLE, pend flags cleared, counters 0.
- Reset asserted mid-frame aborts the frame with no pulse. The next start bit after reset is decoded normally.

## Timing

- key_valid and frame_err are registered. Each is high for exactly one clk cycle, in the cycle after the stop-bit fall event.
- key_code, key_ext and key_release change only in the same cycle key_valid rises.
- Latency from the raw ps2_clk falling edge of the stop bit to key_valid is 2 sync + FILTER_LEN filter + 1 output register cycles, i.e. 11 cycles at default.
- A timeout frame_err occurs TIMEOUT_CYCLES+1 cycles after the last in-frame fall.
- A fall and a timeout in the same cycle: the fall wins and the counter clears.
- Glitches shorter than FILTER_LEN cycles on ps2_clk produce no fall event.
- Minimum accepted PS/2 half-period is FILTER_LEN+2 clk cycles. No back-pressure exists, so the consumer must accept every key_valid.

## Test plan

Benches use a PS/2 clock with a 40 µs period. The timeout test overrides TIMEOUT_CYCLES.

- Single make: frame 0x1C (parity 0, stop 1) -> one key_valid with key_code=0x1C, key_ext=0, key_release=0, and no frame_err.
- Extended break: frames E0, F0, 75 -> exactly one key_valid with key_code=0x75, key_ext=1, key_release=1. The next frame 0x1C gives ext=0, rel=0.
- Parity error: frames F0, then 0x1C with parity=1, then 0x1C good -> frame_err pulses once on the bad frame. The good frame gives key_valid with key_release=0, showing the pend flag was cleared.
- Timeout: start bit plus 4 data bits, then the lines idle high, with TIMEOUT_CYCLES=200 -> frame_err 201 cycles after the last fall. A following frame 0x29 decodes correctly as key_code=0x29.
- Glitch rejection: a 3-cycle low pulse on ps2_clk while IDLE, then frame 0x5A -> no event from the glitch and one key_valid with key_code=0x5A.
- Reset mid-frame: assert reset after the 5th data bit of a frame -> all outputs read 0 during reset and no pulse occurs. Frame 0x16 after release gives key_valid with key_code=0x16.
